decoder_scan_n: RTL

Registered, parametrised N-to-2^N one-hot decoder with a valid/ready input handshake and an optional self-running scan mode. The scan mode steps through every select code and holds each one for a programmable number of cycles. It replaces the fixed combinational 3:8 decoder wherever a registered one-hot select or a built-in exhaustive sweep is needed, for example for chip-select or row-select generation and bring-up self-test.

---
 rtl/decoder_scan_n.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/decoder_scan_n.sv
// Registered N-to-2**N one-hot decoder with a valid/ready input handshake.
// Optional exhaustive scan mode (sweep of every code, DWELL cycles each) is compiled in with DECODER_SCAN_EN.
module decoder_scan_n #(
    parameter int N     = 3,
    parameter int DWELL = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    a,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            scan_start,
    output logic [2**N-1:0] y,
    output logic            y_valid,
    output logic [N-1:0]    code,
    output logic            scan_active,
    output logic            scan_done,
    output logic            state_dbg
);

    localparam int W  = 2**N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    // Handshake: a transfer happens on a rising edge where in_valid & in_ready are both high.
    // in_valid may be held without a transfer; in_ready depends on en, state, scan_start and rst only.

`ifdef DECODER_SCAN_EN

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   dwell_q, dwell_d;
    logic [N-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    y_q, y_d;
    logic [N-1:0]    code_q, code_d;
    logic            yv_q, yv_d;
    logic            active_q, active_d;
    logic            done_q, done_d;

    assign in_ready = en & (state_q == IDLE) & ~scan_start & ~rst;

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        code_d   = code_q;
        yv_d     = yv_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (!en) begin
            // Disable aborts any sweep silently; no done pulse.
            state_d  = IDLE;
            dwell_d  = '0;
            cnt_d    = '0;
            y_d      = '0;
            code_d   = '0;
            yv_d     = 1'b0;
            active_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_start) begin
                        state_d  = SCAN;
                        dwell_d  = '0;
                        cnt_d    = '0;
                        y_d      = W'(1);
                        code_d   = '0;
                        yv_d     = 1'b1;
                        active_d = 1'b1;
                    end else if (in_valid) begin
                        y_d    = W'(1) << a;
                        code_d = a;
                        yv_d   = 1'b1;
                    end
                end
                SCAN: begin
                    if (dwell_q == CW'(DWELL - 1)) begin
                        dwell_d = '0;
                        if (cnt_q == N'(W - 1)) begin
                            state_d  = IDLE;
                            cnt_d    = '0;
                            y_d      = '0;
                            code_d   = '0;
                            yv_d     = 1'b0;
                            active_d = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            cnt_d  = cnt_q + 1'b1;
                            code_d = cnt_q + 1'b1;
                            y_d    = y_q << 1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dwell_q  <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            code_q   <= '0;
            yv_q     <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            code_q   <= code_d;
            yv_q     <= yv_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign y           = y_q;
    assign y_valid     = yv_q;
    assign code        = code_q;
    assign scan_active = active_q;
    assign scan_done   = done_q;
    assign state_dbg   = (state_q == SCAN);

`else

    logic [W-1:0] y_q;
    logic [N-1:0] code_q;
    logic         yv_q;
    logic         unused_scan_start;

    assign unused_scan_start = scan_start;
    assign in_ready          = en & ~rst;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            y_q    <= '0;
            code_q <= '0;
            yv_q   <= 1'b0;
        end else if (in_valid) begin
            y_q    <= W'(1) << a;
            code_q <= a;
            yv_q   <= 1'b1;
        end
    end

    assign y           = y_q;
    assign y_valid     = yv_q;
    assign code        = code_q;
    assign scan_active = 1'b0;
    assign scan_done   = 1'b0;
    assign state_dbg   = 1'b0;

`endif

endmodule
